// File: rtl/int_ctrl_pkg.sv
// Shared constants for the interrupt controller: register offsets, source indices
// and the nesting mask helper.
package int_ctrl_pkg;

  localparam int unsigned IC_NSRC = 6;

  typedef logic [IC_NSRC-1:0] ic_vec_t;

  localparam logic [1:0] ic_pend   = 2'd0;
  localparam logic [1:0] ic_enable = 2'd1;
  localparam logic [1:0] ic_edge   = 2'd2;
  localparam logic [1:0] ic_isr    = 2'd3;

  localparam int unsigned ic_src_timer0 = 0;
  localparam int unsigned ic_src_timer1 = 1;
  localparam int unsigned ic_src_uart   = 2;
  localparam int unsigned ic_src_ext2   = 3;
  localparam int unsigned ic_src_ext3   = 4;
  localparam int unsigned ic_src_ext4   = 5;

  // Bits strictly above a one-hot; everything when nothing is in service.
  function automatic ic_vec_t ic_above(input ic_vec_t hi_oh, input logic valid);
    if (!valid) return '1;
    return ~(hi_oh | (hi_oh - ic_vec_t'(1)));
  endfunction

endpackage

// File: rtl/ic_prio_enc.sv
// Fixed-priority encoder: one-hot of the highest set bit plus a valid flag.
module ic_prio_enc
  import int_ctrl_pkg::*;
(
  input  logic [IC_NSRC-1:0] i_vec,
  output logic [IC_NSRC-1:0] o_onehot,
  output logic               o_valid
);

  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < IC_NSRC; i++) begin
      if (i_vec[i]) o_onehot = ic_vec_t'(1) << i;
    end
  end

  assign o_valid = |i_vec;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: synchronises six requests, latches edge/level pending state,
// masks and prioritises with nesting, and drives registered HWInt[7:2] to CP0.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter logic [5:0] EN_RESET   = 6'b000000,
  parameter logic [5:0] EDGE_RESET = 6'b000000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [5:0]  Irq_in,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  input  logic        Int_take,
  output logic [5:0]  HWInt
);

  logic [5:0] r_s1, r_s2, r_s3;
  logic [5:0] r_pend, r_en, r_edge, r_isr, r_hwint;

  logic [5:0] w_rise, w_w1c, w_take_oh, w_take_clr, w_isr_oh, w_eoi_clr;
  logic [5:0] w_pend_d, w_isr_d, w_req;
  logic       w_take_vld, w_isr_vld, w_take, w_eoi;
  logic       w_unused;

  assign w_unused = ^WD[31:6];

  ic_prio_enc u_take_enc (
    .i_vec   (r_hwint),
    .o_onehot(w_take_oh),
    .o_valid (w_take_vld)
  );

  ic_prio_enc u_isr_enc (
    .i_vec   (r_isr),
    .o_onehot(w_isr_oh),
    .o_valid (w_isr_vld)
  );

  assign w_rise     = r_s2 & ~r_s3;
  assign w_take     = Int_take & w_take_vld;
  assign w_take_clr = w_take ? w_take_oh : 6'b0;
  assign w_w1c      = (WE && Addr == ic_pend) ? WD[5:0] : 6'b0;
  assign w_eoi      = WE && Addr == ic_isr;
  assign w_eoi_clr  = w_eoi ? w_isr_oh : 6'b0;

  // Edge bits: a rise beats any same-cycle clear. Level bits just track the line.
  assign w_pend_d = (r_edge & ((r_pend & ~w_w1c & ~w_take_clr) | w_rise))
                  | (~r_edge & r_s2);

  // EOI clears the current level first, then the take marks the new one.
  assign w_isr_d = (r_isr & ~w_eoi_clr) | w_take_clr;

  assign w_req = r_pend & r_en & ic_above(w_isr_oh, w_isr_vld);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_s3    <= '0;
      r_pend  <= '0;
      r_isr   <= '0;
      r_hwint <= '0;
      r_en    <= EN_RESET;
      r_edge  <= EDGE_RESET;
    end else begin
      r_s1    <= Irq_in;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_pend  <= w_pend_d;
      r_isr   <= w_isr_d;
      r_hwint <= w_req;
      if (WE && Addr == ic_enable) r_en   <= WD[5:0];
      if (WE && Addr == ic_edge)   r_edge <= WD[5:0];
    end
  end

  always_comb begin
    RD = '0;
    unique case (Addr)
      ic_pend:   RD[5:0] = r_pend;
      ic_enable: RD[5:0] = r_en;
      ic_edge:   RD[5:0] = r_edge;
      ic_isr:    RD[5:0] = r_isr;
      default:   RD = '0;
    endcase
  end

  assign HWInt = r_hwint;

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: directed scenarios then random traffic, all
// checked against a behavioural model of the controller's rules.
module tb_int_ctrl;

  localparam logic [5:0] EN_RST   = 6'b100001;
  localparam logic [5:0] EDGE_RST = 6'b000010;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [5:0]  Irq_in = '0;
  logic [1:0]  Addr = '0;
  logic        WE = 1'b0;
  logic [31:0] WD = '0;
  logic        Int_take = 1'b0;
  logic [31:0] RD;
  logic [5:0]  HWInt;

  always #5 Clk = ~Clk;

  int_ctrl #(
    .EN_RESET  (EN_RST),
    .EDGE_RESET(EDGE_RST)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Irq_in  (Irq_in),
    .Addr    (Addr),
    .WE      (WE),
    .WD      (WD),
    .RD      (RD),
    .Int_take(Int_take),
    .HWInt   (HWInt)
  );

  typedef struct packed {
    logic [31:0] rd;
    logic [5:0]  hw;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Model state: synchroniser history, pending, enable, edge mode, in-service, output.
  logic [5:0] m_s1, m_s2, m_s3, m_pend, m_en, m_edge, m_isr, m_hw;
  logic [5:0] cur_irq = '0;

  function automatic int top_bit(input logic [5:0] v);
    for (int i = 5; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] rd_model(input logic [1:0] a);
    case (a)
      2'd0:    return {26'd0, m_pend};
      2'd1:    return {26'd0, m_en};
      2'd2:    return {26'd0, m_edge};
      default: return {26'd0, m_isr};
    endcase
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_s3 = '0;
    m_pend = '0; m_isr = '0; m_hw = '0;
    m_en = EN_RST; m_edge = EDGE_RST;
  endtask

  task automatic model_step(input logic [5:0] irq, input logic [1:0] a, input logic we,
                            input logic [5:0] wd, input logic take);
    logic [5:0] pend_n, isr_n, hw_n;
    int ts, top;
    ts = take ? top_bit(m_hw) : -1;
    for (int i = 0; i < 6; i++) begin
      if (m_edge[i]) begin
        if (m_s2[i] && !m_s3[i]) pend_n[i] = 1'b1;
        else if ((we && a == 2'd0 && wd[i]) || ts == i) pend_n[i] = 1'b0;
        else pend_n[i] = m_pend[i];
      end else begin
        pend_n[i] = m_s2[i];
      end
    end
    isr_n = m_isr;
    if (we && a == 2'd3 && top_bit(m_isr) >= 0) isr_n[top_bit(m_isr)] = 1'b0;
    if (ts >= 0) isr_n[ts] = 1'b1;
    top = top_bit(m_isr);
    for (int i = 0; i < 6; i++) hw_n[i] = m_pend[i] && m_en[i] && (i > top);
    if (we && a == 2'd1) m_en = wd;
    if (we && a == 2'd2) m_edge = wd;
    m_s3 = m_s2; m_s2 = m_s1; m_s1 = irq;
    m_pend = pend_n; m_isr = isr_n; m_hw = hw_n;
  endtask

  task automatic push_exp(input logic [1:0] a);
    exp_t e;
    e.rd = rd_model(a);
    e.hw = m_hw;
    exp_q.push_back(e);
  endtask

  // Called just after a rising edge; applies one cycle of inputs.
  task automatic cyc(input logic [5:0] irq, input logic [1:0] a, input logic we,
                     input logic [5:0] wd, input logic take);
    cur_irq  = irq;
    Irq_in   = irq;
    Addr     = a;
    WE       = we;
    WD       = {26'($urandom), wd};
    Int_take = take;
    push_exp(a);
    @(posedge Clk);
    model_step(irq, a, we, wd, take);
    #1;
  endtask

  task automatic idle(input int n, input logic [1:0] a);
    for (int k = 0; k < n; k++) cyc(cur_irq, a, 1'b0, 6'd0, 1'b0);
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    WE = 1'b0;
    Int_take = 1'b0;
    #1;
    model_reset();
    push_exp(Addr);
    @(negedge Clk);
    #2 Reset = 1'b1;
    @(posedge Clk);
    model_step(cur_irq, Addr, 1'b0, 6'd0, 1'b0);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (RD !== e.rd || HWInt !== e.hw) begin
          miscompares++;
          $display("FAIL vec%0d t=%0t Addr=%0d: RD=%h HWInt=%b, required RD=%h HWInt=%b",
                   vectors, $time, Addr, RD, HWInt, e.rd, e.hw);
        end
      end
    end
  end

  initial begin : stim
    #1;
    do_reset();
    idle(1, 2'd1);
    idle(1, 2'd2);

    // Level source 0: latency in and out.
    cyc(6'b000000, 2'd1, 1'b1, 6'b000001, 1'b0);
    cyc(6'b000000, 2'd2, 1'b1, 6'b000000, 1'b0);
    cyc(6'b000001, 2'd0, 1'b0, 6'd0, 1'b0);
    idle(5, 2'd0);
    cyc(6'b000000, 2'd0, 1'b0, 6'd0, 1'b0);
    idle(5, 2'd0);

    // Edge source 2: one-cycle pulse latches, W1C clears.
    cyc(6'b000000, 2'd2, 1'b1, 6'b000100, 1'b0);
    cyc(6'b000000, 2'd1, 1'b1, 6'b000100, 1'b0);
    cyc(6'b000100, 2'd0, 1'b0, 6'd0, 1'b0);
    cyc(6'b000000, 2'd0, 1'b0, 6'd0, 1'b0);
    idle(5, 2'd0);
    cyc(6'b000000, 2'd0, 1'b1, 6'b000100, 1'b0);
    idle(3, 2'd0);

    // Sources 1 and 4 together, take, then nested source 5.
    cyc(6'b000000, 2'd1, 1'b1, 6'b111111, 1'b0);
    cyc(6'b000000, 2'd2, 1'b1, 6'b111111, 1'b0);
    cyc(6'b010010, 2'd0, 1'b0, 6'd0, 1'b0);
    cyc(6'b000000, 2'd0, 1'b0, 6'd0, 1'b0);
    idle(3, 2'd0);
    cyc(6'b000000, 2'd3, 1'b0, 6'd0, 1'b1);
    idle(3, 2'd3);
    cyc(6'b100000, 2'd0, 1'b0, 6'd0, 1'b0);
    cyc(6'b000000, 2'd0, 1'b0, 6'd0, 1'b0);
    idle(3, 2'd0);
    cyc(6'b000000, 2'd3, 1'b0, 6'd0, 1'b1);
    idle(3, 2'd3);

    // Two EOIs unwind the nesting; source 1 reappears.
    cyc(6'b000000, 2'd3, 1'b1, 6'b101010, 1'b0);
    idle(2, 2'd3);
    cyc(6'b000000, 2'd3, 1'b1, 6'b000000, 1'b0);
    idle(3, 2'd3);

    // Build ISR=010000 with HWInt=100000, then EOI and take in the same cycle.
    cyc(6'b010000, 2'd0, 1'b0, 6'd0, 1'b0);
    cyc(6'b000000, 2'd0, 1'b0, 6'd0, 1'b0);
    idle(3, 2'd0);
    cyc(6'b000000, 2'd3, 1'b0, 6'd0, 1'b1);
    idle(2, 2'd3);
    cyc(6'b100000, 2'd3, 1'b0, 6'd0, 1'b0);
    cyc(6'b000000, 2'd3, 1'b0, 6'd0, 1'b0);
    idle(3, 2'd3);
    cyc(6'b000000, 2'd3, 1'b1, 6'd0, 1'b1);
    idle(2, 2'd3);
    cyc(6'b000000, 2'd3, 1'b0, 6'd0, 1'b1);
    idle(2, 2'd3);

    // Rise on source 3 in the same cycle as its W1C; then reset mid-service.
    cyc(6'b001000, 2'd0, 1'b0, 6'd0, 1'b0);
    cyc(6'b001000, 2'd0, 1'b0, 6'd0, 1'b0);
    cyc(6'b001000, 2'd0, 1'b1, 6'b001000, 1'b0);
    idle(3, 2'd0);
    do_reset();
    idle(1, 2'd3);
    idle(1, 2'd1);
    idle(2, 2'd0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [5:0] irq;
      logic [1:0] a;
      logic       we, take;
      irq = cur_irq;
      if ($urandom_range(0, 5) == 0) irq[$urandom_range(0, 5)] ^= 1'b1;
      a    = 2'($urandom_range(0, 3));
      we   = ($urandom_range(0, 5) == 0);
      take = ($urandom_range(0, 3) == 0);
      if (n == 1500) do_reset();
      cyc(irq, a, we, 6'($urandom), take);
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge Clk);
    #1;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
